// File: rtl/mac_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// mac_ctrl_sequencer
// Generates the per-element ctrl word and the weight/ifmap RAM read address
// stream for the PE/accumulator chain. A run is num_kernels kernels of
// kernel_len elements each, followed by a single flush beat that closes the
// last kernel at the accumulator, followed by a one-cycle done pulse.
//
// Ports
//   clk          in   1           rising-edge clock
//   rst_n        in   1           asynchronous active-low reset
//   start        in   1           run request, sampled only while idle
//   kernel_len   in   LEN_WIDTH   elements per kernel, latched on accepted start
//   num_kernels  in   LEN_WIDTH   kernels per run, latched on accepted start
//   base_addr    in   ADDR_WIDTH  first read address, latched on accepted start
//   stall        in   1           backpressure; freezes issue while high
//   ctrl         out  CTRL_WIDTH  registered ctrl word: [0] valid,
//                                 [MSB] kernel boundary, [MSB-1:1] kernel index
//   rd_en        out  1           RAM read enable (mirrors ctrl[0])
//   rd_addr      out  ADDR_WIDTH  RAM read address, valid when rd_en = 1
//   busy         out  1           high from accepted start until done
//   done         out  1           one-cycle pulse at run end
// -----------------------------------------------------------------------------
module mac_ctrl_sequencer #(
  parameter int CTRL_WIDTH = 9,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  kernel_len,
  input  logic [LEN_WIDTH-1:0]  num_kernels,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  stall,
  output logic [CTRL_WIDTH-1:0] ctrl,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            r_state;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_nk;
  logic [LEN_WIDTH-1:0]  r_elem;
  logic [LEN_WIDTH-1:0]  r_kern;
  // Next address to issue. Elements of consecutive kernels are contiguous,
  // so base + k*len + e is just a running increment (wraps naturally).
  logic [ADDR_WIDTH-1:0] r_addr;
  // Set for a zero-length run: DONE spends one extra cycle so the done
  // pulse lands two edges after the accepted start.
  logic                  r_zero;
  logic [CTRL_WIDTH-1:0] r_ctrl;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_busy;
  logic                  r_done;

  logic [CTRL_WIDTH-1:0] w_beat;
  logic [CTRL_WIDTH-1:0] w_flush;
  logic                  w_last_elem;
  logic                  w_last_kern;

  assign w_last_elem = (r_elem == (r_len - LEN_WIDTH'(1)));
  assign w_last_kern = (r_kern == (r_nk - LEN_WIDTH'(1)));

  // Assemble the data beat and flush beat ctrl words.
  always_comb begin
    w_beat                   = '0;
    w_beat[0]                = 1'b1;
    w_beat[CTRL_WIDTH-1]     = (r_elem == '0);
    w_beat[CTRL_WIDTH-2:1]   = r_kern[CTRL_WIDTH-3:0];
    w_flush                  = '0;
    w_flush[CTRL_WIDTH-1]    = 1'b1;
    w_flush[CTRL_WIDTH-2:1]  = r_nk[CTRL_WIDTH-3:0];
  end

  // Sequencer FSM, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_len     <= '0;
      r_nk      <= '0;
      r_elem    <= '0;
      r_kern    <= '0;
      r_addr    <= '0;
      r_zero    <= 1'b0;
      r_ctrl    <= '0;
      r_rd_addr <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ctrl <= '0;
          r_done <= 1'b0;
          if (start) begin
            r_len  <= kernel_len;
            r_nk   <= num_kernels;
            r_addr <= base_addr;
            r_elem <= '0;
            r_kern <= '0;
            r_busy <= 1'b1;
            if ((kernel_len == '0) || (num_kernels == '0)) begin
              r_zero  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_zero  <= 1'b0;
              r_state <= S_ISSUE;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (stall) begin
            // Bubble: counters and rd_addr hold.
            r_ctrl <= '0;
          end else begin
            r_ctrl    <= w_beat;
            r_rd_addr <= r_addr;
            r_addr    <= r_addr + ADDR_WIDTH'(1);
            if (w_last_elem) begin
              r_elem <= '0;
              r_kern <= r_kern + LEN_WIDTH'(1);
              if (w_last_kern) begin
                r_state <= S_FLUSH;
              end else begin
                r_state <= S_ISSUE;
              end
            end else begin
              r_elem <= r_elem + LEN_WIDTH'(1);
            end
          end
        end
        S_FLUSH: begin
          if (stall) begin
            r_ctrl <= '0;
          end else begin
            r_ctrl  <= w_flush;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_ctrl <= '0;
          if (r_zero) begin
            r_zero <= 1'b0;
            r_done <= 1'b0;
          end else begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ctrl  <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl    = r_ctrl;
  assign rd_en   = r_ctrl[0];
  assign rd_addr = r_rd_addr;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_mac_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mac_ctrl_sequencer
// Directed bench for mac_ctrl_sequencer. Inputs change 1 time unit after the
// rising edge, outputs are checked at the same point (reflecting the edge
// just taken). Edge N is the edge that samples start.
// -----------------------------------------------------------------------------
module tb_mac_ctrl_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] kernel_len;
  logic [7:0] num_kernels;
  logic [7:0] base_addr;
  logic       stall;
  logic [8:0] ctrl;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_c [0:7];
  logic [7:0] exp_a [0:7];

  mac_ctrl_sequencer #(
    .CTRL_WIDTH (9),
    .ADDR_WIDTH (8),
    .LEN_WIDTH  (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .kernel_len  (kernel_len),
    .num_kernels (num_kernels),
    .base_addr   (base_addr),
    .stall       (stall),
    .ctrl        (ctrl),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a start request; returns just after edge N with the start accepted.
  task automatic issue_start(input logic [7:0] len, input logic [7:0] nk, input logic [7:0] base);
    kernel_len  = len;
    num_kernels = nk;
    base_addr   = base;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_ctrl", 32'(ctrl), 32'd0);
    chk("start_done", 32'(done), 32'd0);
  endtask

  // Walk a non-zero run edge by edge against exp_c/exp_a. Stall is held for
  // edges st_at..st_at+st_len-1; a foreign start (different parameters) is
  // presented at edge poke_at.
  task automatic run_seq(input int nbeats, input int st_at, input int st_len,
                         input int poke_at, input logic [8:0] flush_c);
    int b;
    logic stalled;
    b = 0;
    for (int c = 1; c <= nbeats + st_len + 2; c++) begin
      stalled = (c >= st_at) && (c < st_at + st_len);
      stall   = stalled;
      if (c == poke_at) begin
        start       = 1'b1;
        kernel_len  = 8'd7;
        num_kernels = 8'd9;
        base_addr   = 8'h80;
      end
      @(posedge clk); #1;
      stall = 1'b0;
      start = 1'b0;
      if (c == nbeats + st_len + 2) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy",  32'(busy), 32'd0);
        chk("done_ctrl",  32'(ctrl), 32'd0);
      end else if (c == nbeats + st_len + 1) begin
        chk("flush_ctrl", 32'(ctrl),  32'(flush_c));
        chk("flush_rden", 32'(rd_en), 32'd0);
        chk("flush_done", 32'(done),  32'd0);
      end else if (stalled) begin
        chk("bubble_ctrl", 32'(ctrl),    32'd0);
        chk("bubble_rden", 32'(rd_en),   32'd0);
        chk("bubble_addr", 32'(rd_addr), 32'(exp_a[b-1]));
      end else begin
        chk("beat_ctrl", 32'(ctrl),    32'(exp_c[b]));
        chk("beat_rden", 32'(rd_en),   32'd1);
        chk("beat_addr", 32'(rd_addr), 32'(exp_a[b]));
        chk("beat_done", 32'(done),    32'd0);
        b++;
      end
    end
    @(posedge clk); #1;
    chk("post_done", 32'(done), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    kernel_len  = 8'd0;
    num_kernels = 8'd0;
    base_addr   = 8'd0;
    stall       = 1'b0;
    #12;
    chk("rst_ctrl", 32'(ctrl),    32'd0);
    chk("rst_rden", 32'(rd_en),   32'd0);
    chk("rst_addr", 32'(rd_addr), 32'd0);
    chk("rst_busy", 32'(busy),    32'd0);
    chk("rst_done", 32'(done),    32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic run: len 3, 2 kernels, base 0x10.
    exp_c = '{9'h101, 9'h001, 9'h001, 9'h103, 9'h003, 9'h003, 9'h000, 9'h000};
    exp_a = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h00, 8'h00};
    issue_start(8'd3, 8'd2, 8'h10);
    run_seq(6, 0, 0, 0, 9'h104);

    // Same run with two stall cycles after the 2nd beat.
    issue_start(8'd3, 8'd2, 8'h10);
    run_seq(6, 3, 2, 0, 9'h104);

    // Address wrap: base 0xFE, len 4, one kernel.
    exp_c = '{9'h101, 9'h001, 9'h001, 9'h001, 9'h000, 9'h000, 9'h000, 9'h000};
    exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    issue_start(8'd4, 8'd1, 8'hFE);
    run_seq(4, 0, 0, 0, 9'h102);

    // Zero length: done at N+2, busy exactly two cycles, no beats.
    issue_start(8'd0, 8'd5, 8'h40);
    @(posedge clk); #1;
    chk("zero_n1_busy", 32'(busy),  32'd1);
    chk("zero_n1_done", 32'(done),  32'd0);
    chk("zero_n1_rden", 32'(rd_en), 32'd0);
    chk("zero_n1_ctrl", 32'(ctrl),  32'd0);
    @(posedge clk); #1;
    chk("zero_n2_done", 32'(done),  32'd1);
    chk("zero_n2_busy", 32'(busy),  32'd0);
    chk("zero_n2_ctrl", 32'(ctrl),  32'd0);
    @(posedge clk); #1;
    chk("zero_n3_done", 32'(done),  32'd0);

    // Start while busy (plus changed inputs) must not disturb the basic run.
    exp_c = '{9'h101, 9'h001, 9'h001, 9'h103, 9'h003, 9'h003, 9'h000, 9'h000};
    exp_a = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h00, 8'h00};
    issue_start(8'd3, 8'd2, 8'h10);
    run_seq(6, 0, 0, 4, 9'h104);
    chk("poke_idle_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-ISSUE, away from any clock edge.
    issue_start(8'd3, 8'd2, 8'h10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_rden", 32'(rd_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ctrl", 32'(ctrl),    32'd0);
    chk("arst_rden", 32'(rd_en),   32'd0);
    chk("arst_addr", 32'(rd_addr), 32'd0);
    chk("arst_busy", 32'(busy),    32'd0);
    chk("arst_done", 32'(done),    32'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean run after reset.
    exp_c = '{9'h101, 9'h001, 9'h001, 9'h001, 9'h000, 9'h000, 9'h000, 9'h000};
    exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    issue_start(8'd4, 8'd1, 8'hFE);
    run_seq(4, 0, 0, 0, 9'h102);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
